// File: rtl/uart_stim_tx.sv
// UART serial stimulus source: byte FIFO feeding a frame serialiser with
// configurable data bits, parity, stop bits, inter-frame gap and bit-time gating.
module uart_stim_tx #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GAP_BITS   = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          push_valid_i,
  input  logic [7:0]                    push_data_i,
  output logic                          push_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          byte_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
  localparam int unsigned CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W    = PTR_W + 1;
  localparam int unsigned MAX_BITS = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int unsigned BIT_W    = $clog2(MAX_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_GAP  = (GAP_BITS == 0) ? '0 : BIT_W'(GAP_BITS - 1);
  localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               push_en;
  logic               pop;
  logic               bit_end;
  logic               frame_done;
  logic [7:0]         head_masked;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    pop         = 1'b0;
    frame_done  = 1'b0;
    push_en     = push_valid_i && (count_q < OCC_FULL);
    bit_end     = en_i && (cnt_q == CNT_LAST);
    head_masked = mem_q[rd_ptr_q] & DATA_MASK;

    if (en_i && (state_q != S_IDLE)) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (en_i && (count_q != '0)) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q != LAST_STOP) begin
            bit_d = bit_q + BIT_W'(1);
          end else if (GAP_BITS != 0) begin
            state_d = S_GAP;
            bit_d   = '0;
          end else begin
            frame_done = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (bit_q == LAST_GAP) frame_done = 1'b1;
          else                   bit_d = bit_q + BIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A finished frame chains straight into the next start bit when bytes wait.
    if (frame_done) begin
      state_d = S_IDLE;
      if (count_q != '0) pop = 1'b1;
    end

    if (pop) begin
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = head_masked;
      par_d   = (^head_masked) ^ (PARITY == 2);
    end

    wr_ptr_d = push_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_en && !pop)      count_d = count_q + OCC_W'(1);
    else if (!push_en && pop) count_d = count_q - OCC_W'(1);

    // Line level follows the next state so tx_o lines up with the state register.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign push_ready_o = (count_q < OCC_FULL);
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign byte_done_o  = frame_done;
  assign fifo_count_o = count_q;

endmodule
